// File: rtl/picorv32_axil_master.sv
// picorv32_axil_master: bridges the PicoRV32 native memory bus to a single AXI4-Lite master port.
// Optional watchdog: define AXIM_TIMEOUT_EN. Revision 1.0.
`default_nettype none

module picorv32_axil_master #(
    parameter int ADDR_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              resetn,

    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    input  logic [3:0]        mem_wstrb,
    output logic              mem_ready,
    output logic [31:0]       mem_rdata,
    output logic              bus_err,

    output logic [ADDR_W-1:0] m_axi_awaddr,
    output logic [2:0]        m_axi_awprot,
    output logic              m_axi_awvalid,
    input  logic              m_axi_awready,
    output logic [31:0]       m_axi_wdata,
    output logic [3:0]        m_axi_wstrb,
    output logic              m_axi_wvalid,
    input  logic              m_axi_wready,
    input  logic [1:0]        m_axi_bresp,
    input  logic              m_axi_bvalid,
    output logic              m_axi_bready,
    output logic [ADDR_W-1:0] m_axi_araddr,
    output logic [2:0]        m_axi_arprot,
    output logic              m_axi_arvalid,
    input  logic              m_axi_arready,
    input  logic [31:0]       m_axi_rdata,
    input  logic [1:0]        m_axi_rresp,
    input  logic              m_axi_rvalid,
    output logic              m_axi_rready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WRITE = 3'd1,
        WRESP = 3'd2,
        RADDR = 3'd3,
        RDATA = 3'd4
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   awaddr_nxt;
    logic                awvalid_nxt;
    logic [31:0]         wdata_nxt;
    logic [3:0]          wstrb_nxt;
    logic                wvalid_nxt;
    logic                bready_nxt;
    logic [ADDR_W-1:0]   araddr_nxt;
    logic [2:0]          arprot_nxt;
    logic                arvalid_nxt;
    logic                rready_nxt;
    logic                ready_nxt;
    logic [31:0]         rdata_nxt;
    logic                err_nxt;
    logic                timeout_hit;

    assign m_axi_awprot = 3'b000;

`ifdef AXIM_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] tmo_cnt;

    assign timeout_hit = (state != IDLE) && (tmo_cnt == CNT_W'(TIMEOUT_CYCLES));

    // Held at zero in IDLE, so it starts from zero at every launch.
    always_ff @(posedge clk) begin
        if (!resetn || state == IDLE) begin
            tmo_cnt <= '0;
        end else if (!timeout_hit) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end
`else
    logic unused_timeout;

    assign timeout_hit    = 1'b0;
    assign unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            m_axi_awaddr  <= '0;
            m_axi_awvalid <= 1'b0;
            m_axi_wdata   <= '0;
            m_axi_wstrb   <= '0;
            m_axi_wvalid  <= 1'b0;
            m_axi_bready  <= 1'b0;
            m_axi_araddr  <= '0;
            m_axi_arprot  <= '0;
            m_axi_arvalid <= 1'b0;
            m_axi_rready  <= 1'b0;
            mem_ready     <= 1'b0;
            mem_rdata     <= '0;
            bus_err       <= 1'b0;
        end else begin
            state         <= state_nxt;
            m_axi_awaddr  <= awaddr_nxt;
            m_axi_awvalid <= awvalid_nxt;
            m_axi_wdata   <= wdata_nxt;
            m_axi_wstrb   <= wstrb_nxt;
            m_axi_wvalid  <= wvalid_nxt;
            m_axi_bready  <= bready_nxt;
            m_axi_araddr  <= araddr_nxt;
            m_axi_arprot  <= arprot_nxt;
            m_axi_arvalid <= arvalid_nxt;
            m_axi_rready  <= rready_nxt;
            mem_ready     <= ready_nxt;
            mem_rdata     <= rdata_nxt;
            bus_err       <= err_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        awaddr_nxt  = m_axi_awaddr;
        awvalid_nxt = m_axi_awvalid;
        wdata_nxt   = m_axi_wdata;
        wstrb_nxt   = m_axi_wstrb;
        wvalid_nxt  = m_axi_wvalid;
        bready_nxt  = m_axi_bready;
        araddr_nxt  = m_axi_araddr;
        arprot_nxt  = m_axi_arprot;
        arvalid_nxt = m_axi_arvalid;
        rready_nxt  = m_axi_rready;
        ready_nxt   = 1'b0;
        rdata_nxt   = mem_rdata;
        err_nxt     = 1'b0;

        case (state)
            IDLE: begin
                // mem_valid is still high during the mem_ready pulse; do not relaunch then.
                if (mem_valid && !mem_ready) begin
                    if (mem_wstrb != 4'b0000) begin
                        awaddr_nxt  = mem_addr[ADDR_W-1:0];
                        wdata_nxt   = mem_wdata;
                        wstrb_nxt   = mem_wstrb;
                        awvalid_nxt = 1'b1;
                        wvalid_nxt  = 1'b1;
                        state_nxt   = WRITE;
                    end else begin
                        araddr_nxt  = mem_addr[ADDR_W-1:0];
                        arprot_nxt  = mem_instr ? 3'b100 : 3'b000;
                        arvalid_nxt = 1'b1;
                        state_nxt   = RADDR;
                    end
                end
            end
            WRITE: begin
                if (m_axi_awvalid && m_axi_awready) begin
                    awvalid_nxt = 1'b0;
                end
                if (m_axi_wvalid && m_axi_wready) begin
                    wvalid_nxt = 1'b0;
                end
                if (!awvalid_nxt && !wvalid_nxt) begin
                    bready_nxt = 1'b1;
                    state_nxt  = WRESP;
                end
            end
            WRESP: begin
                if (m_axi_bvalid && m_axi_bready) begin
                    bready_nxt = 1'b0;
                    ready_nxt  = 1'b1;
                    err_nxt    = (m_axi_bresp != 2'b00);
                    state_nxt  = IDLE;
                end
            end
            RADDR: begin
                if (m_axi_arvalid && m_axi_arready) begin
                    arvalid_nxt = 1'b0;
                    rready_nxt  = 1'b1;
                    state_nxt   = RDATA;
                end
            end
            RDATA: begin
                if (m_axi_rvalid && m_axi_rready) begin
                    rready_nxt = 1'b0;
                    rdata_nxt  = m_axi_rdata;
                    ready_nxt  = 1'b1;
                    err_nxt    = (m_axi_rresp != 2'b00);
                    state_nxt  = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // A handshake that advances the state on the expiry edge still wins.
        if (timeout_hit && state_nxt == state) begin
            awvalid_nxt = 1'b0;
            wvalid_nxt  = 1'b0;
            bready_nxt  = 1'b0;
            arvalid_nxt = 1'b0;
            rready_nxt  = 1'b0;
            ready_nxt   = 1'b1;
            err_nxt     = 1'b1;
            if (state == RADDR || state == RDATA) begin
                rdata_nxt = 32'hDEADBEEF;
            end
            state_nxt   = IDLE;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_picorv32_axil_master.sv
// Self-checking bench for picorv32_axil_master: delay-configurable AXI-Lite slave plus latency/data model.
`default_nettype none

module tb_picorv32_axil_master;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        mem_valid = 1'b0;
    logic        mem_instr = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_wstrb = '0;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        bus_err;
    logic [31:0] awaddr;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready = 1'b0;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready = 1'b0;
    logic [1:0]  bresp = '0;
    logic        bvalid = 1'b0;
    logic        bready;
    logic [31:0] araddr;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = '0;
    logic        rvalid = 1'b0;
    logic        rready;

    always #5 clk = ~clk;

    picorv32_axil_master #(.ADDR_W(32), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .resetn(resetn),
        .mem_valid(mem_valid), .mem_instr(mem_instr), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ready(mem_ready),
        .mem_rdata(mem_rdata), .bus_err(bus_err),
        .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid),
        .m_axi_awready(awready), .m_axi_wdata(wdata), .m_axi_wstrb(wstrb),
        .m_axi_wvalid(wvalid), .m_axi_wready(wready), .m_axi_bresp(bresp),
        .m_axi_bvalid(bvalid), .m_axi_bready(bready), .m_axi_araddr(araddr),
        .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
        .m_axi_rdata(rdata), .m_axi_rresp(rresp), .m_axi_rvalid(rvalid),
        .m_axi_rready(rready)
    );

    int errors = 0;
    int checks = 0;

    // Slave configuration: each ready/valid appears after the given number of waiting cycles.
    int          aw_dly = 0, w_dly = 0, ar_dly = 0, b_dly = 0, r_dly = 0;
    logic [1:0]  cfg_bresp = 2'b00, cfg_rresp = 2'b00;
    logic [31:0] cfg_rdata = '0;
    int          aw_cnt = 0, w_cnt = 0, ar_cnt = 0, b_cnt = 0, r_cnt = 0;
    int          aw_hs = 0, w_hs = 0, ar_hs = 0;
    logic [31:0] cap_awaddr = '0, cap_wdata = '0, cap_araddr = '0;
    logic [3:0]  cap_wstrb = '0;
    logic [2:0]  cap_arprot = '0;

    always @(negedge clk) begin
        if (awvalid) begin
            awready = (aw_cnt >= aw_dly);
            if (awready) begin cap_awaddr = awaddr; aw_hs++; end
            aw_cnt++;
        end else begin awready = 1'b0; aw_cnt = 0; end
        if (wvalid) begin
            wready = (w_cnt >= w_dly);
            if (wready) begin cap_wdata = wdata; cap_wstrb = wstrb; w_hs++; end
            w_cnt++;
        end else begin wready = 1'b0; w_cnt = 0; end
        if (arvalid) begin
            arready = (ar_cnt >= ar_dly);
            if (arready) begin cap_araddr = araddr; cap_arprot = arprot; ar_hs++; end
            ar_cnt++;
        end else begin arready = 1'b0; ar_cnt = 0; end
        if (bready) begin
            bvalid = (b_cnt >= b_dly + 1);
            bresp  = bvalid ? cfg_bresp : 2'b00;
            b_cnt++;
        end else begin bvalid = 1'b0; bresp = 2'b00; b_cnt = 0; end
        if (rready) begin
            rvalid = (r_cnt >= r_dly + 1);
            rdata  = rvalid ? cfg_rdata : $urandom;
            rresp  = rvalid ? cfg_rresp : 2'b00;
            r_cnt++;
        end else begin rvalid = 1'b0; rdata = $urandom; rresp = 2'b00; r_cnt = 0; end
    end

    // Protocol monitor, sampled just after each active edge.
    int          ready_cnt = 0, awv_cyc = 0, wv_cyc = 0, rr_cyc = 0;
    logic        p_awvalid = 1'b0, p_wvalid = 1'b0, p_arvalid = 1'b0;
    logic [31:0] p_awaddr = '0, p_wdata = '0, p_araddr = '0;

    always @(posedge clk) begin
        #1;
        if (resetn) begin
            checks++;
            if (!mem_ready && ((p_awvalid && !awready && !awvalid) ||
                               (p_wvalid && !wready && !wvalid) ||
                               (p_arvalid && !arready && !arvalid))) begin
                errors++;
                $display("FAIL valid_drop: aw=%0b w=%0b ar=%0b required held until handshake", awvalid, wvalid, arvalid);
            end
            checks++;
            if ((p_awvalid && !awready && awvalid && awaddr !== p_awaddr) ||
                (p_wvalid && !wready && wvalid && wdata !== p_wdata) ||
                (p_arvalid && !arready && arvalid && araddr !== p_araddr)) begin
                errors++;
                $display("FAIL payload_stable: awaddr=%h wdata=%h araddr=%h changed while valid", awaddr, wdata, araddr);
            end
            checks++;
            if (((awvalid || wvalid) && (arvalid || rready)) || (bready && (awvalid || wvalid))) begin
                errors++;
                $display("FAIL overlap: aw=%0b w=%0b b=%0b ar=%0b r=%0b required exclusive", awvalid, wvalid, bready, arvalid, rready);
            end
        end
        ready_cnt += int'(mem_ready);
        awv_cyc   += int'(awvalid);
        wv_cyc    += int'(wvalid);
        rr_cyc    += int'(rready);
        p_awvalid = awvalid; p_wvalid = wvalid; p_arvalid = arvalid;
        p_awaddr  = awaddr;  p_wdata  = wdata;  p_araddr  = araddr;
    end

    task automatic set_slave(input int adl, input int wdl, input int bdl, input int ardl, input int rdl,
                             input logic [1:0] br, input logic [1:0] rr, input logic [31:0] rd);
        aw_dly = adl; w_dly = wdl; b_dly = bdl; ar_dly = ardl; r_dly = rdl;
        cfg_bresp = br; cfg_rresp = rr; cfg_rdata = rd;
    endtask

    // Presents one request and waits (bounded) for its mem_ready; lat counts cycles from the launch edge.
    task automatic run_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                           input logic [3:0] strb, input logic instr,
                           output int lat, output logic [31:0] rd, output logic err, output logic ok);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = addr; mem_wdata = wd; mem_instr = instr;
        mem_wstrb = wr ? strb : 4'b0000;
        lat = -1; ok = 1'b0; rd = '0; err = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (mem_ready) begin lat = i; ok = 1'b1; break; end
        end
        rd = mem_rdata; err = bus_err;
        mem_valid = 1'b0; mem_wstrb = 4'b0000;
    endtask

    task automatic test_reset;
        resetn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({mem_ready, mem_rdata, bus_err, awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
             araddr, arprot, arvalid, rready} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%0b rdata=%h err=%0b awv=%0b wv=%0b arv=%0b required all zero",
                     mem_ready, mem_rdata, bus_err, awvalid, wvalid, arvalid);
        end
        resetn = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write;
        int lat; logic [31:0] rd; logic err, ok; int rc0;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        rc0 = ready_cnt;
        run_txn(1'b1, 32'h04, 32'h12345678, 4'hF, 1'b0, lat, rd, err, ok);
        checks++;
        if (!ok || lat != 3 || err !== 1'b0) begin
            errors++;
            $display("FAIL write_basic: ok=%0b lat=%0d err=%0b required ok=1 lat=3 err=0", ok, lat, err);
        end
        checks++;
        if (cap_awaddr !== 32'h04 || cap_wdata !== 32'h12345678 || cap_wstrb !== 4'hF || awprot !== 3'b000) begin
            errors++;
            $display("FAIL write_payload: awaddr=%h wdata=%h wstrb=%h awprot=%0d required 4 12345678 f 0",
                     cap_awaddr, cap_wdata, cap_wstrb, awprot);
        end
        @(negedge clk);
        checks++;
        if (mem_ready !== 1'b0 || ready_cnt - rc0 != 1) begin
            errors++;
            $display("FAIL write_pulse: ready=%0b pulses=%0d required 0 and 1", mem_ready, ready_cnt - rc0);
        end
    endtask

    task automatic test_read;
        int lat; logic [31:0] rd; logic err, ok;
        set_slave(0, 0, 0, 0, 4, 2'b00, 2'b00, 32'hCAFEF00D);
        rr_cyc = 0;
        run_txn(1'b0, 32'h08, 32'h0, 4'h0, 1'b1, lat, rd, err, ok);
        checks++;
        if (!ok || rd !== 32'hCAFEF00D || err !== 1'b0 || lat != 7) begin
            errors++;
            $display("FAIL read_basic: ok=%0b rdata=%h err=%0b lat=%0d required cafef00d err=0 lat=7", ok, rd, err, lat);
        end
        checks++;
        if (cap_araddr !== 32'h08 || cap_arprot !== 3'b100 || rr_cyc != 6) begin
            errors++;
            $display("FAIL read_axi: araddr=%h arprot=%0d rready_cycles=%0d required 8 4 6", cap_araddr, cap_arprot, rr_cyc);
        end
    endtask

    task automatic test_skewed_write;
        int lat; logic [31:0] rd; logic err, ok; int rc0;
        set_slave(3, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
        awv_cyc = 0; wv_cyc = 0; rc0 = ready_cnt;
        run_txn(1'b1, 32'h10, 32'hA5A5_0001, 4'h3, 1'b0, lat, rd, err, ok);
        checks++;
        if (!ok || lat != 6 || wv_cyc != 1 || awv_cyc != 4) begin
            errors++;
            $display("FAIL skew_write: ok=%0b lat=%0d wvalid_cyc=%0d awvalid_cyc=%0d required lat=6 1 4", ok, lat, wv_cyc, awv_cyc);
        end
        @(negedge clk);
        checks++;
        if (ready_cnt - rc0 != 1 || cap_wstrb !== 4'h3) begin
            errors++;
            $display("FAIL skew_once: pulses=%0d wstrb=%h required 1 and 3", ready_cnt - rc0, cap_wstrb);
        end
    endtask

    task automatic test_errors;
        int lat; logic [31:0] rd; logic err, ok;
        set_slave(0, 1, 2, 0, 0, 2'b10, 2'b00, 32'h0);
        run_txn(1'b1, 32'h20, 32'h1, 4'h1, 1'b0, lat, rd, err, ok);
        checks++;
        if (!ok || err !== 1'b1) begin
            errors++;
            $display("FAIL bresp_err: ok=%0b err=%0b required 1 1", ok, err);
        end
        set_slave(0, 0, 0, 1, 1, 2'b00, 2'b11, 32'h5EED_1234);
        run_txn(1'b0, 32'h24, 32'h0, 4'h0, 1'b0, lat, rd, err, ok);
        checks++;
        if (!ok || err !== 1'b1 || rd !== 32'h5EED_1234) begin
            errors++;
            $display("FAIL rresp_err: ok=%0b err=%0b rdata=%h required 1 1 5eed1234", ok, err, rd);
        end
        @(negedge clk);
        checks++;
        if (bus_err !== 1'b0 || mem_rdata !== 32'h5EED_1234) begin
            errors++;
            $display("FAIL err_pulse: err=%0b rdata=%h required 0 5eed1234", bus_err, mem_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int rc0, aw0; logic ok;
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0B0B_0B0B);
        rc0 = ready_cnt; aw0 = aw_hs; ok = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h00; mem_wdata = 32'h7777_0000; mem_wstrb = 4'hF; mem_instr = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_ready) begin ok = 1'b1; break; end
        end
        mem_addr = 32'h08; mem_wstrb = 4'h0;
        @(negedge clk);
        checks++;
        if (!ok || awvalid !== 1'b0 || arvalid !== 1'b0 || mem_ready !== 1'b0) begin
            errors++;
            $display("FAIL b2b_no_relaunch: ok=%0b awv=%0b arv=%0b ready=%0b required 1 0 0 0", ok, awvalid, arvalid, mem_ready);
        end
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b1 || araddr !== 32'h08) begin
            errors++;
            $display("FAIL b2b_second_start: arvalid=%0b araddr=%h required 1 8", arvalid, araddr);
        end
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (mem_ready) begin ok = 1'b1; break; end
        end
        mem_valid = 1'b0;
        checks++;
        if (!ok || mem_rdata !== 32'h0B0B_0B0B || ready_cnt - rc0 != 2 || aw_hs - aw0 != 1) begin
            errors++;
            $display("FAIL b2b_result: ok=%0b rdata=%h pulses=%0d aw_hs=%0d required 1 0b0b0b0b 2 1",
                     ok, mem_rdata, ready_cnt - rc0, aw_hs - aw0);
        end
    endtask

    task automatic test_random;
        int lat, exp_lat, adl, wdl, bdl, ardl, rdl; logic [31:0] rd, addr, wd, rdv, last_rd;
        logic err, ok, wr, instr; logic [3:0] strb; logic [1:0] resp;
        last_rd = mem_rdata;
        for (int n = 0; n < 40; n++) begin
            wr = 1'($urandom_range(0, 1)); instr = 1'($urandom_range(0, 1));
            addr = $urandom & 32'hFFFF_FFFC; wd = $urandom; rdv = $urandom;
            strb = 4'($urandom_range(1, 15));
            resp = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            adl = $urandom_range(0, 3); wdl = $urandom_range(0, 3); bdl = $urandom_range(0, 3);
            ardl = $urandom_range(0, 3); rdl = $urandom_range(0, 3);
            set_slave(adl, wdl, bdl, ardl, rdl, resp, resp, rdv);
            run_txn(wr, addr, wd, strb, instr, lat, rd, err, ok);
            exp_lat = wr ? ((adl > wdl ? adl : wdl) + bdl + 3) : (ardl + rdl + 3);
            if (!wr) last_rd = rdv;
            checks++;
            if (!ok || lat != exp_lat || err !== (resp != 2'b00) || rd !== last_rd) begin
                errors++;
                $display("FAIL rand_txn[%0d]: wr=%0b ok=%0b lat=%0d err=%0b rdata=%h required lat=%0d err=%0b rdata=%h",
                         n, wr, ok, lat, err, rd, exp_lat, resp != 2'b00, last_rd);
            end
            checks++;
            if (wr ? (cap_awaddr !== addr || cap_wdata !== wd || cap_wstrb !== strb)
                   : (cap_araddr !== addr || cap_arprot !== (instr ? 3'b100 : 3'b000))) begin
                errors++;
                $display("FAIL rand_payload[%0d]: wr=%0b awaddr=%h wdata=%h wstrb=%h araddr=%h arprot=%0d required addr=%h wdata=%h wstrb=%h instr=%0b",
                         n, wr, cap_awaddr, cap_wdata, cap_wstrb, cap_araddr, cap_arprot, addr, wd, strb, instr);
            end
        end
    endtask

    task automatic test_reset_mid;
        int rc0; logic seen;
        set_slave(0, 0, 0, 0, 20, 2'b00, 2'b00, 32'h1111_2222);
        seen = 1'b0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = 32'h30; mem_wstrb = 4'h0; mem_instr = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rready) begin seen = 1'b1; break; end
        end
        rc0 = ready_cnt;
        resetn = 1'b0; mem_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (!seen || {mem_ready, bus_err, awvalid, wvalid, bready, arvalid, rready, mem_rdata} !== '0) begin
            errors++;
            $display("FAIL reset_mid: in_rdata=%0b ready=%0b err=%0b arv=%0b rready=%0b rdata=%h required rdata-state reached, all 0",
                     seen, mem_ready, bus_err, arvalid, rready, mem_rdata);
        end
        resetn = 1'b1;
        repeat (25) @(negedge clk);
        checks++;
        if (ready_cnt != rc0 || rready !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_ready: pulses=%0d rready=%0b required 0 0", ready_cnt - rc0, rready);
        end
    endtask

`ifdef AXIM_TIMEOUT_EN
    task automatic test_timeout;
        int lat; logic [31:0] rd; logic err, ok;
        set_slave(0, 0, 0, 100000, 0, 2'b00, 2'b00, 32'h0);
        run_txn(1'b0, 32'h40, 32'h0, 4'h0, 1'b0, lat, rd, err, ok);
        checks++;
        if (!ok || err !== 1'b1 || rd !== 32'hDEADBEEF || lat < 255 || lat > 257) begin
            errors++;
            $display("FAIL timeout_read: ok=%0b err=%0b rdata=%h lat=%0d required 1 1 deadbeef ~255", ok, err, rd, lat);
        end
        @(negedge clk);
        checks++;
        if (arvalid !== 1'b0 || rready !== 1'b0) begin
            errors++;
            $display("FAIL timeout_drop: arvalid=%0b rready=%0b required 0 0", arvalid, rready);
        end
        set_slave(0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0);
    endtask
`endif

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_write;
        test_read;
        test_skewed_write;
        test_errors;
        test_back_to_back;
        test_random;
        test_reset_mid;
`ifdef AXIM_TIMEOUT_EN
        test_timeout;
`endif
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
